rom_stream_reader: RTL

- Read-side sequencer for the alpha coefficient ROMs: 128-entry, 1-cycle-latency, registered-output lookup tables such as mem_gen2.
- On a start command it walks a contiguous address window, drives the ROM address and read strobe, and captures the returned words.
- Captured words are presented as a valid/ready stream to the downstream datapath, with last-beat marking.
- A 2-entry capture buffer absorbs ROM latency under backpressure, so no word is lost or duplicated.

---
 rtl/rom_stream_reader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rom_stream_reader.sv
// Read sequencer for registered-output coefficient ROMs: walks an address window
// and streams the returned words over valid/ready with a 2-entry fall-through buffer.
module rom_stream_reader #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_rd_en,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [ADDR_WIDTH:0]        rem_q, rem_d;
    logic                       inflight_q, inflight_d;
    logic                       inflight_last_q, inflight_last_d;
    logic [1:0][DATA_WIDTH-1:0] buf_data_q;
    logic [1:0]                 buf_last_q;
    logic                       rd_ptr_q;
    logic [1:0]                 occ_q, occ_d;

    logic       head_valid;
    logic       pop;
    logic       pop_buf;
    logic       store;
    logic       wr_idx;
    logic [1:0] total;
    logic [1:0] after_pop;
    logic       issue;

    // Stream handshake: a word transfers in any cycle where out_valid and out_ready
    // are both high; out_valid never drops and out_data/out_last never change
    // while a word waits for out_ready.
    // A word arriving from the ROM is presented directly when the buffer is empty.
    assign head_valid = (occ_q != 2'd0);
    assign out_valid  = head_valid || inflight_q;
    assign out_data   = head_valid ? buf_data_q[rd_ptr_q] : rom_data;
    assign out_last   = head_valid ? buf_last_q[rd_ptr_q] : inflight_last_q;

    assign pop     = out_valid && out_ready;
    assign pop_buf = pop && head_valid;
    assign store   = inflight_q && !(pop && !head_valid);
    assign wr_idx  = rd_ptr_q ^ occ_q[0];
    assign occ_d   = occ_q + {1'b0, store} - {1'b0, pop_buf};

    // Words held plus the word in flight, less the one leaving this cycle.
    assign total     = occ_q + {1'b0, inflight_q};
    assign after_pop = total - {1'b0, pop};
    assign issue     = (state_q == ST_RUN) && (rem_q != '0) && (after_pop < 2'd2);

    assign rom_addr    = addr_q;
    assign rom_rd_en   = issue;
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_FIN);
    assign dbg_state_o = state_q;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        inflight_d      = issue;
        inflight_last_d = issue && (rem_q == (ADDR_WIDTH + 1)'(1));
        case (state_q)
            ST_IDLE: begin
                // An empty window still spends one cycle in RUN so busy is seen.
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = count;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - (ADDR_WIDTH + 1)'(1);
                end
                if ((rem_q == '0) && (after_pop == 2'd0)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_data_q      <= '0;
            buf_last_q      <= '0;
            rd_ptr_q        <= 1'b0;
            occ_q           <= 2'd0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            occ_q           <= occ_d;
            if (store) begin
                buf_data_q[wr_idx] <= rom_data;
                buf_last_q[wr_idx] <= inflight_last_q;
            end
            if (pop_buf) begin
                rd_ptr_q <= !rd_ptr_q;
            end
        end
    end

endmodule
